// File: rtl/bullet_pool_ctrl.sv
// ---------------------------------------------------------------------------
// bullet_pool_ctrl
// Schedules a player's pool of bullet instances: turns fire requests into a
// one-cycle launch pulse on a free slot, enforces cooldown / magazine /
// reload timing on frame ticks, and accumulates per-slot hits into a
// saturating counter.
//
// Build option:
//   BULLET_RR_ARB_EN  defined   -> round-robin slot arbitration (rr_ptr)
//                     undefined -> fixed priority, lowest free slot wins
// ---------------------------------------------------------------------------
module bullet_pool_ctrl #(
  parameter int N_SLOTS        = 4,
  parameter int MAG_SIZE       = 6,
  parameter int COOLDOWN_TICKS = 8,
  parameter int RELOAD_TICKS   = 60
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               attack,
  input  logic               defend,
  input  logic               reload,
  input  logic [N_SLOTS-1:0] slot_busy,
  input  logic [N_SLOTS-1:0] slot_hit,
  output logic [N_SLOTS-1:0] slot_fire,
  output logic [3:0]         ammo,
  output logic [1:0]         state,
  output logic               can_fire,
  output logic [15:0]        hit_count,
  output logic               hit_pulse
);

  localparam int CNT_MAX = (RELOAD_TICKS > COOLDOWN_TICKS) ? RELOAD_TICKS : COOLDOWN_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  // Cooldown load is only meaningful when COOLDOWN_TICKS > 1; clamp to keep it non-negative.
  localparam int CD_LOAD = (COOLDOWN_TICKS > 1) ? (COOLDOWN_TICKS - 2) : 0;

  localparam logic [CNT_W-1:0] RELOAD_LOAD_C   = CNT_W'(RELOAD_TICKS - 1);
  localparam logic [CNT_W-1:0] COOLDOWN_LOAD_C = CNT_W'(CD_LOAD);
  localparam logic [3:0]       MAG_C           = 4'(MAG_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX_C      = IDX_W'(N_SLOTS - 1);

  typedef enum logic [1:0] {
    ST_READY    = 2'd0,
    ST_COOLDOWN = 2'd1,
    ST_RELOAD   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         ammo_q, ammo_d;
  logic [N_SLOTS-1:0] slot_fire_q, slot_fire_d;
  logic [15:0]        hit_count_q, hit_count_d;
  logic               hit_pulse_q, hit_pulse_d;

  logic [N_SLOTS-1:0] free_s;
  logic               any_free_s;
  logic [IDX_W-1:0]   grant_idx_s;
  logic [N_SLOTS-1:0] grant_s;
  logic [16:0]        hit_sum_s;

`ifdef BULLET_RR_ARB_EN
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
`endif

  // Number of set bits in a hit vector (at most 8 slots, fits in 4 bits).
  function automatic logic [3:0] popcount(input logic [N_SLOTS-1:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < N_SLOTS; i++) begin
      n = n + 4'(v[i]);
    end
    return n;
  endfunction

  // A slot just granted stays masked busy until its launch pulse completes,
  // so a tick in the very next cycle cannot grant it a second time.
  assign free_s     = ~(slot_busy | slot_fire_q);
  assign any_free_s = |free_s;

  // Slot arbiter: scan from highest search offset down so the lowest offset wins.
  always_comb begin
    grant_idx_s = '0;
    for (int k = N_SLOTS - 1; k >= 0; k--) begin
`ifdef BULLET_RR_ARB_EN
      grant_idx_s = free_s[(int'(rr_ptr_q) + k) % N_SLOTS]
                    ? IDX_W'((int'(rr_ptr_q) + k) % N_SLOTS) : grant_idx_s;
`else
      grant_idx_s = free_s[k] ? IDX_W'(k) : grant_idx_s;
`endif
    end
    grant_s = any_free_s ? (N_SLOTS'(1'b1) << grant_idx_s) : '0;
  end

  // Fire/cooldown/reload FSM next-state; only frame ticks advance it.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ammo_d      = ammo_q;
    slot_fire_d = '0;
`ifdef BULLET_RR_ARB_EN
    rr_ptr_d    = rr_ptr_q;
`endif
    if (frame_tick) begin
      case (state_q)
        ST_READY: begin
          if (reload && (ammo_q < MAG_C)) begin
            state_d = ST_RELOAD;
            cnt_d   = RELOAD_LOAD_C;
          end else if (attack && !defend && (ammo_q != 4'd0) && any_free_s) begin
            slot_fire_d = grant_s;
            ammo_d      = ammo_q - 4'd1;
`ifdef BULLET_RR_ARB_EN
            rr_ptr_d    = (grant_idx_s == LAST_IDX_C) ? '0 : grant_idx_s + IDX_W'(1);
`endif
            if (ammo_q == 4'd1) begin
              state_d = ST_RELOAD;
              cnt_d   = RELOAD_LOAD_C;
            end else if (COOLDOWN_TICKS > 1) begin
              state_d = ST_COOLDOWN;
              cnt_d   = COOLDOWN_LOAD_C;
            end else begin
              state_d = ST_READY;
            end
          end else begin
            // Denied or idle request is dropped; nothing changes.
            state_d = ST_READY;
          end
        end
        ST_COOLDOWN: begin
          if (cnt_q == '0) begin
            state_d = ST_READY;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_RELOAD: begin
          if (cnt_q == '0) begin
            state_d = ST_READY;
            ammo_d  = MAG_C;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_READY;
          cnt_d   = '0;
        end
      endcase
    end else begin
      slot_fire_d = '0;
    end
  end

  // Hit accumulation runs every cycle, independent of frame ticks.
  always_comb begin
    hit_sum_s   = {1'b0, hit_count_q} + 17'(popcount(slot_hit));
    hit_count_d = hit_sum_s[16] ? 16'hFFFF : hit_sum_s[15:0];
    hit_pulse_d = |slot_hit;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_READY;
      cnt_q       <= '0;
      ammo_q      <= MAG_C;
      slot_fire_q <= '0;
      hit_count_q <= 16'h0000;
      hit_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ammo_q      <= ammo_d;
      slot_fire_q <= slot_fire_d;
      hit_count_q <= hit_count_d;
      hit_pulse_q <= hit_pulse_d;
    end
  end

`ifdef BULLET_RR_ARB_EN
  // Round-robin search start pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  assign slot_fire = slot_fire_q;
  assign ammo      = ammo_q;
  assign state     = state_q;
  assign hit_count = hit_count_q;
  assign hit_pulse = hit_pulse_q;
  assign can_fire  = (state_q == ST_READY) && (ammo_q != 4'd0) && any_free_s;

endmodule
